prog_sequencer: RTL and testbench

- Run-control block that drives the program counter's control inputs: PC reset, count enable, branch enable and branch offset.
- Takes the bench Start/Done handshake, clears the PC while Start is held, and runs the program once Start drops.
- Watches the fetched instruction for the halt opcode, then raises Done.
- Also counts executed cycles and flags runaway programs.

---
 rtl/prog_sequencer.sv | 162 ++++++++++++++++
 tb/tb_prog_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//
// Run-control block for a small processor. It drives the program counter's
// control inputs from a Start/Done handshake:
//   - while start_i is high the PC is held at 0 (CLEAR),
//   - when start_i drops the program runs until the halt opcode is fetched,
//     the cycle budget runs out, or the PC would run off the end of memory,
//   - done_o / fault_o report how the run ended and cycle_count_o how long
//     it took.
//
// Handshake: start_i is a level. High requests (or re-requests) a run and
// holds the PC cleared; the run begins on the first clock edge that samples
// it low. done_o rises on the edge that leaves RUN and stays high until the
// next run clears it.
//
// Ports:
//   clk_i            system clock, all state changes on posedge
//   rst_ni           asynchronous active-low reset
//   start_i          run request (level)
//   pc_i             current program counter value
//   instr_i          instruction at pc_i (combinational ROM read)
//   branch_taken_i   current instruction branches
//   branch_offset_i  two's-complement offset of the taken branch
//   pc_reset_o       force PC to 0
//   pc_en_o          PC count enable
//   pc_branch_en_o   PC branch select
//   pc_offset_o      offset presented to the PC
//   running_o        high while the program runs
//   done_o           program finished (halt or fault), registered
//   fault_o          run ended by timeout or PC wrap, registered
//   cycle_count_o    RUN cycles in the current or last program
//   state_o          debug view of the FSM state
// ---------------------------------------------------------------------------
module prog_sequencer #(
    parameter int                  PC_W       = 10,
    parameter int                  INSTR_W    = 9,
    parameter logic [INSTR_W-1:0]  HALT_OP    = {INSTR_W{1'b1}},
    parameter int                  CNT_W      = 16,
    parameter logic [CNT_W-1:0]    MAX_CYCLES = {CNT_W{1'b1}}
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_offset_i,
    output logic               pc_reset_o,
    output logic               pc_en_o,
    output logic               pc_branch_en_o,
    output logic [PC_W-1:0]    pc_offset_o,
    output logic               running_o,
    output logic               done_o,
    output logic               fault_o,
    output logic [CNT_W-1:0]   cycle_count_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Count value seen on the last permitted RUN edge.
    localparam logic [CNT_W-1:0] LAST_CYCLE = MAX_CYCLES - 1'b1;

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              halt;

    assign halt = (instr_i == HALT_OP);

    // PC-side outputs depend only on state and the fetched instruction /
    // branch decode, never on start_i, so they cannot glitch on the handshake.
    always_comb begin
        state_d        = state_q;
        done_d         = done_q;
        fault_d        = fault_q;
        cnt_d          = cnt_q;
        pc_reset_o     = 1'b0;
        pc_en_o        = 1'b0;
        pc_branch_en_o = 1'b0;
        pc_offset_o    = '0;
        running_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_CLEAR;
            end

            S_CLEAR: begin
                pc_reset_o = 1'b1;
                done_d     = 1'b0;
                fault_d    = 1'b0;
                cnt_d      = '0;
                if (!start_i) state_d = S_RUN;
            end

            S_RUN: begin
                running_o      = 1'b1;
                pc_en_o        = ~halt;
                pc_branch_en_o = ~halt & branch_taken_i;
                if (pc_branch_en_o) pc_offset_o = branch_offset_i;

                // Saturating: the counter sticks at all-ones.
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;

                if (start_i) begin
                    // Abort: restart without reporting completion.
                    state_d = S_CLEAR;
                end else if (halt) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b0;
                end else if (cnt_q == LAST_CYCLE) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end else if ((pc_i == {PC_W{1'b1}}) && !branch_taken_i) begin
                    // Sequential step off the top of memory; the PC still
                    // increments this cycle and so wraps to 0.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end
            end

            S_DONE: begin
                if (start_i) state_d = S_CLEAR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done_o        = done_q;
    assign fault_o       = fault_q;
    assign cycle_count_o = cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
//
// Bench for prog_sequencer. The bench owns a program counter, an instruction
// ROM and a branch table (each branch entry is taken a limited number of
// times, like a loop counter in the ALU). For every run a reference model
// walks the program from address 0 and produces the expected per-cycle
// trace and the final Done/Fault/CycleCount/Pc values.
// ---------------------------------------------------------------------------
module tb_prog_sequencer;

  localparam int PC_W = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W = 16;
  localparam logic [INSTR_W-1:0] HALT = 9'h1FF;
  localparam int MAX_CYC = 1100;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic [PC_W-1:0] pc;
  logic [INSTR_W-1:0] instr;
  logic br_taken;
  logic [PC_W-1:0] br_off;

  logic pc_reset_o, pc_en_o, pc_branch_en_o, running_o, done_o, fault_o;
  logic [PC_W-1:0] pc_offset_o;
  logic [CNT_W-1:0] cycle_count_o;
  logic [1:0] state_o;

  // environment: ROM, branch decode, program counter
  logic [INSTR_W-1:0] rom [1024];
  int br_left [1024];
  logic [PC_W-1:0] br_offs [1024];

  assign instr = rom[pc];
  assign br_taken = (br_left[pc] != 0);
  assign br_off = br_offs[pc];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (pc_reset_o) pc <= '0;
    else if (pc_branch_en_o) pc <= pc + pc_offset_o;
    else if (pc_en_o) pc <= pc + 10'd1;
  end

  prog_sequencer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .HALT_OP(HALT), .CNT_W(CNT_W),
    .MAX_CYCLES(16'd1100)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pc_i(pc), .instr_i(instr),
    .branch_taken_i(br_taken), .branch_offset_i(br_off),
    .pc_reset_o(pc_reset_o), .pc_en_o(pc_en_o), .pc_branch_en_o(pc_branch_en_o),
    .pc_offset_o(pc_offset_o), .running_o(running_o), .done_o(done_o),
    .fault_o(fault_o), .cycle_count_o(cycle_count_o), .state_o(state_o)
  );

  // scoreboard state
  int n_checks = 0;
  int n_fail = 0;
  logic [23:0] exp_q[$];  // {pc_reset, running, pc_en, br_en, offset, pc}
  logic m_fault;
  int m_cnt;
  logic [PC_W-1:0] m_pc;

  // invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if ({pc_reset_o & pc_en_o, pc_branch_en_o & ~pc_en_o,
           (pc_offset_o != '0) & ~pc_branch_en_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL invariant t=%0t pc_reset=%b pc_en=%b br_en=%b off=%h (required no overlap, br_en->pc_en, off=0 unless br_en)",
                 $time, pc_reset_o, pc_en_o, pc_branch_en_o, pc_offset_o);
      end
    end
  end

  // Reference model: walk the program from address 0 using the run rules.
  task automatic model_run();
    int left [1024];
    logic [PC_W-1:0] p, nxt, off;
    int cnt;
    bit en, br;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) left[i] = br_left[i];
    p = '0;
    cnt = 0;
    while (1) begin
      en = (rom[p] != HALT);
      br = en && (left[p] != 0);
      off = br ? br_offs[p] : '0;
      exp_q.push_back({1'b0, 1'b1, en, br, off, p});
      cnt++;
      if (br) left[p]--;
      nxt = !en ? p : (br ? p + off : p + 10'd1);
      if (!en) begin m_fault = 1'b0; break; end
      if (cnt == MAX_CYC) begin m_fault = 1'b1; p = nxt; break; end
      if (p == 10'h3FF && !br) begin m_fault = 1'b1; p = nxt; break; end
      p = nxt;
    end
    m_pc = p;
    m_cnt = cnt;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) begin
      rom[i] = 9'($urandom_range(0, 510));
      br_left[i] = 0;
      br_offs[i] = '0;
    end
  endtask

  // Start handshake (start held for 'hold' edges), then follow the run.
  task automatic run_program(input int hold);
    int n;
    bit pend;
    logic [PC_W-1:0] pend_addr;
    logic [23:0] exp, got;
    logic [29:0] fin_exp, fin_got;
    model_run();
    start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({pc_reset_o, pc_en_o, running_o} !== 3'b100) begin
        n_fail++;
        $display("FAIL clear_outputs cyc=%0d got reset/en/run=%b required 100", i, {pc_reset_o, pc_en_o, running_o});
      end
      if (i > 0) begin
        n_checks++;
        if ({done_o, fault_o, cycle_count_o} !== 18'h0) begin
          n_fail++;
          $display("FAIL clear_status cyc=%0d got done=%b fault=%b cnt=%0d required 0/0/0", i, done_o, fault_o, cycle_count_o);
        end
      end
    end
    #1 start = 1'b0;
    n = exp_q.size();
    pend = 1'b0;
    pend_addr = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (pend) br_left[pend_addr]--;
      #1;
      exp = exp_q.pop_front();
      got = {pc_reset_o, running_o, pc_en_o, pc_branch_en_o, pc_offset_o, pc};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL run_trace cyc=%0d got %h required %h", i, got, exp);
      end
      pend = pc_branch_en_o;
      pend_addr = pc;
    end
    @(posedge clk); #1;
    if (pend) br_left[pend_addr]--;
    #1;
    fin_exp = {1'b1, m_fault, 16'(m_cnt), m_pc, 2'b00};
    fin_got = {done_o, fault_o, cycle_count_o, pc, running_o, pc_en_o};
    n_checks++;
    if (fin_got !== fin_exp) begin
      n_fail++;
      $display("FAIL run_end got done/fault/cnt/pc/run/en=%h required %h", fin_got, fin_exp);
    end
    repeat (3) @(posedge clk);
    #1;
    fin_got = {done_o, fault_o, cycle_count_o, pc, running_o, pc_en_o};
    n_checks++;
    if (fin_got !== fin_exp) begin
      n_fail++;
      $display("FAIL done_hold got %h required %h", fin_got, fin_exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] all_out;
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    all_out = {pc_reset_o, pc_en_o, pc_branch_en_o, pc_offset_o, running_o, done_o, fault_o, cycle_count_o};
    n_checks++;
    if (all_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values got %h required 0", all_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    all_out = {pc_reset_o, pc_en_o, pc_branch_en_o, pc_offset_o, running_o, done_o, fault_o, cycle_count_o};
    n_checks++;
    if (all_out !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_values got %h required 0", all_out);
    end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[5] = HALT;
    run_program(3);
    n_checks++;
    if ({done_o, fault_o, cycle_count_o, pc} !== {1'b1, 1'b0, 16'd6, 10'd5}) begin
      n_fail++;
      $display("FAIL halt_result got done=%b fault=%b cnt=%0d pc=%0d required 1/0/6/5", done_o, fault_o, cycle_count_o, pc);
    end
  endtask

  task automatic test_branch();
    clear_rom();
    rom[7] = HALT;
    br_left[2] = 1;
    br_offs[2] = 10'h3FE;
    run_program(2);
    n_checks++;
    if ({done_o, fault_o, cycle_count_o, pc} !== {1'b1, 1'b0, 16'd11, 10'd7}) begin
      n_fail++;
      $display("FAIL branch_result got done=%b fault=%b cnt=%0d pc=%0d required 1/0/11/7", done_o, fault_o, cycle_count_o, pc);
    end
  endtask

  // Consecutive random programs, each started straight from DONE.
  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      clear_rom();
      for (int i = 0; i < 1024; i++) begin
        if ($urandom_range(0, 15) == 0) rom[i] = HALT;
        if ($urandom_range(0, 9) == 0) begin
          br_left[i] = int'($urandom_range(1, 3));
          br_offs[i] = 10'($urandom);
        end
      end
      run_program(int'($urandom_range(2, 4)));
    end
  endtask

  task automatic test_timeout();
    int a, k;
    clear_rom();
    a = int'($urandom_range(4, 40));
    k = int'($urandom_range(1, a));
    br_left[a] = 1000000;
    br_offs[a] = 10'(1024 - k);
    run_program(2);
    n_checks++;
    if ({done_o, fault_o, cycle_count_o} !== {1'b1, 1'b1, 16'd1100}) begin
      n_fail++;
      $display("FAIL timeout_result got done=%b fault=%b cnt=%0d required 1/1/1100", done_o, fault_o, cycle_count_o);
    end
  endtask

  task automatic test_wrap();
    clear_rom();
    run_program(2);
    n_checks++;
    if ({done_o, fault_o, cycle_count_o, pc} !== {1'b1, 1'b1, 16'd1024, 10'd0}) begin
      n_fail++;
      $display("FAIL wrap_result got done=%b fault=%b cnt=%0d pc=%0d required 1/1/1024/0", done_o, fault_o, cycle_count_o, pc);
    end
  endtask

  task automatic test_abort();
    clear_rom();
    rom[9] = HALT;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({running_o, cycle_count_o, pc} !== {1'b1, 16'd4, 10'd4}) begin
      n_fail++;
      $display("FAIL abort_pre got run=%b cnt=%0d pc=%0d required 1/4/4", running_o, cycle_count_o, pc);
    end
    start = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({pc_reset_o, running_o, done_o, fault_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_clear got reset/run/done/fault=%b required 1000", {pc_reset_o, running_o, done_o, fault_o});
    end
    run_program(2);
    n_checks++;
    if ({done_o, fault_o, cycle_count_o, pc} !== {1'b1, 1'b0, 16'd10, 10'd9}) begin
      n_fail++;
      $display("FAIL abort_rerun got done=%b fault=%b cnt=%0d pc=%0d required 1/0/10/9", done_o, fault_o, cycle_count_o, pc);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] all_out;
    clear_rom();
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    all_out = {pc_reset_o, pc_en_o, pc_branch_en_o, pc_offset_o, running_o, done_o, fault_o, cycle_count_o};
    n_checks++;
    if (all_out !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset got %h required 0 before any clock edge", all_out);
    end
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    all_out = {pc_reset_o, pc_en_o, pc_branch_en_o, pc_offset_o, running_o, done_o, fault_o, cycle_count_o};
    n_checks++;
    if (all_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold got %h required 0", all_out);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    all_out = {pc_reset_o, pc_en_o, pc_branch_en_o, pc_offset_o, running_o, done_o, fault_o, cycle_count_o};
    n_checks++;
    if (all_out !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle got %h required 0", all_out);
    end
    rom[3] = HALT;
    run_program(2);
    n_checks++;
    if ({done_o, fault_o, cycle_count_o, pc} !== {1'b1, 1'b0, 16'd4, 10'd3}) begin
      n_fail++;
      $display("FAIL reset_rerun got done=%b fault=%b cnt=%0d pc=%0d required 1/0/4/3", done_o, fault_o, cycle_count_o, pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom[i] = '0;
      br_left[i] = 0;
      br_offs[i] = '0;
    end
    test_reset();
    test_halt();
    test_branch();
    test_back_to_back();
    test_timeout();
    test_wrap();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
